// File: rtl/skewed_shift_bank.sv
// rtl/skewed_shift_bank.sv - multi-channel circular word bank with skewed STREAM output
module skewed_shift_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int CHANNELS   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [1:0]                            cmd_code,
    input  logic [CHANNELS*LENGTH*DATA_WIDTH-1:0] data_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        data_write,
    output logic [CHANNELS*LENGTH*DATA_WIDTH-1:0] data_out,
    output logic [CHANNELS*DATA_WIDTH-1:0]        stream_data,
    output logic [CHANNELS-1:0]                   stream_valid,
    output logic                                  done
);

    localparam int TW        = $clog2(LENGTH + CHANNELS);
    localparam int LAST_BEAT = LENGTH + CHANNELS - 2;

    localparam logic [1:0] CMD_UPLOAD = 2'd0;
    localparam logic [1:0] CMD_LOAD   = 2'd1;
    localparam logic [1:0] CMD_WRITE  = 2'd2;
    localparam logic [1:0] CMD_STREAM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } state_t;

    state_t state;
    logic [TW-1:0] t;

    // Packed so that the whole bank lines up with data_in/data_out bit for bit.
    logic [CHANNELS-1:0][LENGTH-1:0][DATA_WIDTH-1:0] mem;

    logic [CHANNELS-1:0] active;
    logic                last;

    assign cmd_ready = (state != ST_STREAM);

    // Channel c is inside its LENGTH-beat window once the wavefront reaches it.
    always_comb begin
        active = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            active[c] = (32'(t) >= 32'(c)) && (32'(t) < 32'(c + LENGTH));
        end
    end

    assign last = (32'(t) == 32'(LAST_BEAT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            t            <= '0;
            mem          <= '0;
            data_out     <= '0;
            stream_data  <= '0;
            stream_valid <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_STREAM: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (active[c]) begin
                            stream_data[c*DATA_WIDTH +: DATA_WIDTH] <= mem[c][0];
                            stream_valid[c]                         <= 1'b1;
                            for (int k = 0; k < LENGTH - 1; k++) begin
                                mem[c][k] <= mem[c][k+1];
                            end
                            mem[c][LENGTH-1] <= mem[c][0];
                        end else begin
                            stream_data[c*DATA_WIDTH +: DATA_WIDTH] <= '0;
                            stream_valid[c]                         <= 1'b0;
                        end
                    end
                    t    <= t + 1'b1;
                    done <= last;
                    if (last) begin
                        state <= ST_IDLE;
                        t     <= '0;
                    end
                end
                default: begin
                    stream_data  <= '0;
                    stream_valid <= '0;
                    done         <= 1'b0;
                    if (cmd_valid) begin
                        case (cmd_code)
                            CMD_UPLOAD: data_out <= mem;
                            CMD_LOAD:   mem      <= data_in;
                            CMD_WRITE: begin
                                for (int c = 0; c < CHANNELS; c++) begin
                                    for (int k = 0; k < LENGTH - 1; k++) begin
                                        mem[c][k] <= mem[c][k+1];
                                    end
                                    mem[c][LENGTH-1] <= data_write[c*DATA_WIDTH +: DATA_WIDTH];
                                end
                            end
                            CMD_STREAM: begin
                                state <= ST_STREAM;
                                t     <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
